// File: rtl/sram_array_if.sv
// sram_array_if: access/clear bus between a requester and sram_array.
// Ports: req/RW/Address/DataIn/clr from the requester;
//        ready/busy/DataOut/rvalid (and perr with SRAM_ARRAY_PARITY_EN) back.
interface sram_array_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) ();
    localparam int ADDR_W = $clog2(DEPTH);

    logic              req;
    logic              RW;
    logic [ADDR_W-1:0] Address;
    logic [WIDTH-1:0]  DataIn;
    logic              clr;
    logic              ready;
    logic              busy;
    logic [WIDTH-1:0]  DataOut;
    logic              rvalid;
`ifdef SRAM_ARRAY_PARITY_EN
    logic              perr;
`endif

    modport master (
        output req, RW, Address, DataIn, clr,
`ifdef SRAM_ARRAY_PARITY_EN
        input  perr,
`endif
        input  ready, busy, DataOut, rvalid
    );

    modport slave (
        input  req, RW, Address, DataIn, clr,
`ifdef SRAM_ARRAY_PARITY_EN
        output perr,
`endif
        output ready, busy, DataOut, rvalid
    );
endinterface

// File: rtl/sram_array.sv
// sram_array: single-port word array with a self-clearing sweep.
// Ports: clk, rst (async active-low), bus (sram_array_if.slave).
// Option: SRAM_ARRAY_PARITY_EN adds a stored even-parity bit and bus.perr.
module sram_array #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input logic         clk,
    input logic         rst,
    sram_array_if.slave bus
);
    typedef enum logic {CLEAR, IDLE} state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   LIM  = (ADDR_W + 1)'(DEPTH);

`ifdef SRAM_ARRAY_PARITY_EN
    localparam int MW = WIDTH + 1;
`else
    localparam int MW = WIDTH;
`endif

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic              busy_q;
    logic [MW-1:0]     mem [DEPTH];

    logic              acc;
    logic              in_range;
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [MW-1:0]     wd;
    logic [ADDR_W-1:0] ridx;
    logic [MW-1:0]     rword;

    // busy is the registered image of the CLEAR state
    assign bus.busy  = busy_q;
    assign bus.ready = ~busy_q & ~bus.clr;

    assign acc      = bus.req & bus.ready;
    assign in_range = {1'b0, bus.Address} < LIM;

    // one write port shared by the sweep and host writes
    assign we = busy_q | (acc & bus.RW & in_range);
    assign wa = busy_q ? ptr : bus.Address;

`ifdef SRAM_ARRAY_PARITY_EN
    assign wd = busy_q ? '0 : {^bus.DataIn, bus.DataIn};
`else
    assign wd = busy_q ? '0 : bus.DataIn;
`endif

    assign ridx  = in_range ? bus.Address : '0;
    assign rword = mem[ridx];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= CLEAR;
            ptr    <= '0;
            busy_q <= 1'b1;
        end else begin
            unique case (state)
                CLEAR: begin
                    if (ptr == LAST) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        ptr    <= '0;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                IDLE: begin
                    if (bus.clr) begin
                        state  <= CLEAR;
                        busy_q <= 1'b1;
                        ptr    <= '0;
                    end
                end
                default: begin
                    state  <= CLEAR;
                    busy_q <= 1'b1;
                    ptr    <= '0;
                end
            endcase
        end
    end

    // array contents are not reset; the sweep defines them
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wa] <= wd;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.DataOut <= '0;
            bus.rvalid  <= 1'b0;
        end else begin
            bus.rvalid <= acc & ~bus.RW;
            if (acc & ~bus.RW) begin
                bus.DataOut <= in_range ? rword[WIDTH-1:0] : '0;
            end
        end
    end

`ifdef SRAM_ARRAY_PARITY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.perr <= 1'b0;
        end else begin
            bus.perr <= acc & ~bus.RW & in_range &
                        (rword[WIDTH] != ^rword[WIDTH-1:0]);
        end
    end
`endif
endmodule

// File: tb/tb_sram_array.sv
// tb_sram_array: directed vector bench for sram_array (WIDTH=8, DEPTH=12).
// Table of single-cycle accesses plus hand sequences for sweep/reset/clr.
module tb_sram_array;
    localparam int W = 8;
    localparam int D = 12;

    logic clk;
    logic rst;
    int   total;
    int   passed;

    sram_array_if #(.WIDTH(W), .DEPTH(D)) bus ();

    sram_array #(.WIDTH(W), .DEPTH(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       req;
        logic       rw;
        logic [3:0] addr;
        logic [7:0] din;
        logic       exp_rv;
        logic [7:0] exp_do;
    } vec_t;

    vec_t v [16];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else
            passed++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rq, input logic rw,
                         input logic [3:0] a, input logic [7:0] d,
                         input logic c);
        bus.req     = rq;
        bus.RW      = rw;
        bus.Address = a;
        bus.DataIn  = d;
        bus.clr     = c;
    endtask

    // counts cycles with busy=1; optional clr pulse mid-sweep must be ignored
    task automatic sweep_len(output int n, input int clr_at);
        n = 0;
        while (bus.busy && n < 100) begin
            bus.clr = (n == clr_at);
            step();
            n++;
        end
        bus.clr = 1'b0;
    endtask

    initial begin
        int n;
        total  = 0;
        passed = 0;
        rst    = 1'b0;
        drive(1'b0, 1'b0, 4'd0, 8'h00, 1'b0);

        v[0]  = '{1'b1, 1'b1, 4'd3,  8'hA5, 1'b0, 8'h00};
        v[1]  = '{1'b1, 1'b0, 4'd3,  8'h00, 1'b1, 8'hA5};
        v[2]  = '{1'b0, 1'b0, 4'd0,  8'h00, 1'b0, 8'hA5};
        v[3]  = '{1'b1, 1'b1, 4'd13, 8'h3C, 1'b0, 8'hA5};
        v[4]  = '{1'b1, 1'b0, 4'd13, 8'h00, 1'b1, 8'h00};
        v[5]  = '{1'b1, 1'b0, 4'd1,  8'h00, 1'b1, 8'h00};
        v[6]  = '{1'b1, 1'b1, 4'd7,  8'h5A, 1'b0, 8'h00};
        v[7]  = '{1'b1, 1'b0, 4'd7,  8'h00, 1'b1, 8'h5A};
        v[8]  = '{1'b1, 1'b1, 4'd0,  8'h0F, 1'b0, 8'h5A};
        v[9]  = '{1'b1, 1'b1, 4'd11, 8'hF0, 1'b0, 8'h5A};
        v[10] = '{1'b1, 1'b0, 4'd0,  8'h00, 1'b1, 8'h0F};
        v[11] = '{1'b1, 1'b0, 4'd11, 8'h00, 1'b1, 8'hF0};
        v[12] = '{1'b1, 1'b0, 4'd3,  8'h00, 1'b1, 8'hA5};
        v[13] = '{1'b1, 1'b0, 4'd12, 8'h00, 1'b1, 8'h00};
        v[14] = '{1'b0, 1'b1, 4'd5,  8'h77, 1'b0, 8'h00};
        v[15] = '{1'b1, 1'b1, 4'd5,  8'hFF, 1'b0, 8'h00};

        repeat (3) step();
        chk("rst_busy", 32'(bus.busy), 32'd1);
        chk("rst_ready", 32'(bus.ready), 32'd0);
        chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
        chk("rst_dout", 32'(bus.DataOut), 32'h00);

        rst = 1'b1;
        sweep_len(n, -1);
        chk("init_sweep_len", 32'(n), 32'd12);
        chk("idle_ready", 32'(bus.ready), 32'd1);

        for (int a = 0; a < D; a++) begin
            drive(1'b1, 1'b0, 4'(a), 8'h00, 1'b0);
            step();
            chk($sformatf("init_rd%0d", a),
                {23'd0, bus.rvalid, bus.DataOut}, {23'd0, 1'b1, 8'h00});
        end

        for (int i = 0; i < 16; i++) begin
            drive(v[i].req, v[i].rw, v[i].addr, v[i].din, 1'b0);
            step();
            chk($sformatf("vec%0d_rvalid", i), 32'(bus.rvalid),
                32'(v[i].exp_rv));
            chk($sformatf("vec%0d_dout", i), 32'(bus.DataOut),
                32'(v[i].exp_do));
        end

        // clr beats a same-cycle read; clr mid-sweep is ignored
        drive(1'b1, 1'b0, 4'd5, 8'h00, 1'b1);
        #1;
        chk("clr_blocks_ready", 32'(bus.ready), 32'd0);
        step();
        drive(1'b1, 1'b1, 4'd6, 8'h99, 1'b0);
        chk("clr_no_rvalid", 32'(bus.rvalid), 32'd0);
        chk("clr_busy", 32'(bus.busy), 32'd1);
        chk("sweep_ready", 32'(bus.ready), 32'd0);
        sweep_len(n, 3);
        chk("clr_sweep_len", 32'(n), 32'd12);
        drive(1'b1, 1'b0, 4'd5, 8'h00, 1'b0);
        step();
        chk("clr_rd5", {23'd0, bus.rvalid, bus.DataOut},
            {23'd0, 1'b1, 8'h00});
        drive(1'b1, 1'b0, 4'd6, 8'h00, 1'b0);
        step();
        chk("sweep_wr_dropped", {23'd0, bus.rvalid, bus.DataOut},
            {23'd0, 1'b1, 8'h00});

        // read accepted just before clr still completes
        drive(1'b1, 1'b1, 4'd4, 8'h77, 1'b0);
        step();
        drive(1'b1, 1'b0, 4'd4, 8'h00, 1'b0);
        step();
        drive(1'b0, 1'b0, 4'd0, 8'h00, 1'b1);
        chk("preclr_rd", {23'd0, bus.rvalid, bus.DataOut},
            {23'd0, 1'b1, 8'h77});
        step();
        bus.clr = 1'b0;
        chk("preclr_rv_drop", 32'(bus.rvalid), 32'd0);
        sweep_len(n, -1);
        chk("preclr_sweep_len", 32'(n), 32'd12);
        chk("sweep_holds_dout", 32'(bus.DataOut), 32'h77);

        // reset in sweep cycle 6 restarts a full sweep
        drive(1'b0, 1'b0, 4'd0, 8'h00, 1'b1);
        step();
        bus.clr = 1'b0;
        repeat (6) step();
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_busy", 32'(bus.busy), 32'd1);
        chk("midrst_dout", 32'(bus.DataOut), 32'h00);
        step();
        rst = 1'b1;
        sweep_len(n, -1);
        chk("midrst_sweep_len", 32'(n), 32'd12);

`ifdef SRAM_ARRAY_PARITY_EN
        drive(1'b1, 1'b1, 4'd2, 8'h01, 1'b0);
        step();
        drive(1'b1, 1'b0, 4'd2, 8'h00, 1'b0);
        step();
        chk("par_ok", {22'd0, bus.perr, bus.rvalid, bus.DataOut},
            {22'd0, 1'b0, 1'b1, 8'h01});
        drive(1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
        dut.mem[2][W] = ~dut.mem[2][W];
        step();
        drive(1'b1, 1'b0, 4'd2, 8'h00, 1'b0);
        step();
        chk("par_err", {22'd0, bus.perr, bus.rvalid, bus.DataOut},
            {22'd0, 1'b1, 1'b1, 8'h01});
`endif

        drive(1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
        step();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/sram_array.md
SRAM_ARRAY -- requirements
Module: sram_array

Interface
REQ-001 Parameter WIDTH, default 8: data word width in bits, legal range 1..32.
REQ-002 Parameter DEPTH, default 16: number of words, legal range 2..256, need not be a power of two.
REQ-003 Parameter ADDR_W, default $clog2(DEPTH): address width, derived, never overridden.
REQ-004 Port clk  input  1: single clock, all state updates on the rising edge.
REQ-005 Port rst  input  1: asynchronous, active-low reset; asserts immediately, deasserts synchronously to clk.
REQ-006 Port req  input  1: access request, sampled on rising clk.
REQ-007 Port RW  input  1: 1 = write, 0 = read, qualified by req.
REQ-008 Port Address  input  ADDR_W: word address of the access.
REQ-009 Port DataIn  input  WIDTH: write data.
REQ-010 Port clr  input  1: single-cycle request to zero the whole array.
REQ-011 Port ready  output  1: access accepted this cycle when req & ready.
REQ-012 Port busy  output  1: clear sweep in progress.
REQ-013 Port DataOut  output  WIDTH: registered read data.
REQ-014 Port rvalid  output  1: DataOut carries new read data this cycle; one-cycle pulse.

Function
REQ-015 FSM states CLEAR and IDLE; leaving reset, the FSM enters CLEAR with sweep pointer = 0.
REQ-016 CLEAR: write 0 to word[ptr] each cycle, ptr+1; after word DEPTH-1 -> IDLE; takes exactly DEPTH cycles; busy=1, ready=0 throughout.
REQ-017 IDLE: busy=0; ready = ~clr (combinational).
REQ-018 clr in IDLE -> CLEAR next cycle, ptr=0; clr wins over a same-cycle req, which is not accepted; clr during CLEAR is ignored.
REQ-019 Accepted write: word[Address] <= DataIn at the accepting edge; rvalid stays 0.
REQ-020 Accepted read: DataOut = word[Address] and rvalid=1 on the following cycle; latency exactly 1 cycle.
REQ-021 Back-to-back accesses: one per cycle; a read the cycle after a write to the same address returns the new data.
REQ-022 Address >= DEPTH: write dropped with no array change; read returns 0 with rvalid=1.
REQ-023 DataOut holds its last value when rvalid=0; a clear sweep does not change DataOut.
REQ-024 A read accepted in the cycle before clr still completes: rvalid=1 with pre-clear data.

Reset
REQ-025 While rst=0: ready=0, busy=1, rvalid=0, DataOut=0, FSM=CLEAR, ptr=0; array contents are undefined until the sweep completes.
REQ-026 Reset asserted mid-sweep or mid-access aborts the operation; the sweep restarts from ptr=0 after deassertion.

Configuration
REQ-027 Macro SRAM_ARRAY_PARITY_EN defined: each word stores one extra even-parity bit computed on write, the clear sweep stores parity 0, and an added output port perr (1 bit, reset 0) pulses with rvalid when the stored parity mismatches the read data.
REQ-028 Macro undefined: no parity storage, no perr port; behaviour otherwise identical.

Verification (WIDTH=8, DEPTH=12)
REQ-029 Release rst, hold req=0 -> busy=1 for exactly 12 cycles, then busy=0, ready=1; reads of 0..11 return 0x00.
REQ-030 Write 0xA5@3, then read 3 next cycle -> one cycle later DataOut=0xA5, rvalid=1 for one cycle.
REQ-031 Write 0x3C@13 (out of range), then read 13 -> DataOut=0x00 and rvalid=1; a read of 1 returns 0x00, showing no aliasing.
REQ-032 Write 0xFF@5, assert clr with req=1 RW=0 Address=5 -> no rvalid, busy=1 for 12 cycles, then read 5 returns 0x00.
REQ-033 Drive rst=0 at sweep cycle 6, release -> busy=1 for a full 12 cycles after release.
REQ-034 With SRAM_ARRAY_PARITY_EN, force a stored parity bit to flip on word 2 (value 0x01), then read 2 -> DataOut=0x01, rvalid=1, perr=1.
